// File: rtl/mem_port_sched.sv
// Round-robin scheduler sharing one single-ported data memory among NREQ requesters.
// Optional feature: define MEM_PORT_LOCK_EN to add the lock port for back-to-back re-grants.
module mem_port_sched #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [NREQ*DATA_W-1:0] wdata,
`ifdef MEM_PORT_LOCK_EN
    input  logic [NREQ-1:0]        lock,
`endif
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    g_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    wcnt;
    logic [DATA_W-1:0]   rdata_q;

    logic                found;
    logic                advance;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    ptr_next;
    logic [NREQ-1:0]     g_onehot;

`ifdef MEM_PORT_LOCK_EN
    logic                after_resp;
`endif

    // ------------------------------------------------------------------
    // Winner selection: first set req bit starting at ptr, wrapping.
    // ------------------------------------------------------------------
    // NOTE: every variable assigned in a combinational block gets a default
    // at the top, otherwise the tool infers a latch for the unassigned paths.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        cand    = '0;
        advance = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`ifdef MEM_PORT_LOCK_EN
        // A locked owner re-wins the IDLE cycle right after its RESP.
        if (after_resp && lock[g_q] && req[g_q]) begin
            found   = 1'b1;
            winner  = g_q;
            advance = 1'b0;
        end
`endif
    end

    assign ptr_next = (winner == IDX_W'(NREQ - 1)) ? '0 : winner + 1'b1;
    assign g_onehot = NREQ'(1) << g_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (found) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (wcnt == '0) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded only from registered state
    // ------------------------------------------------------------------
    always_comb begin
        gnt       = '0;
        ack       = '0;
        busy      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            S_IDLE: ;
            S_ISSUE: begin
                gnt       = g_onehot;
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            S_WAIT: begin
                gnt  = g_onehot;
                busy = 1'b1;
            end
            S_RESP: begin
                gnt  = g_onehot;
                ack  = g_onehot;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign rdata = rdata_q;

    // ------------------------------------------------------------------
    // Datapath: command latch, pointer, latency counter, read capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            g_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wcnt    <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        g_q     <= winner;
                        we_q    <= we[winner];
                        addr_q  <= addr[int'(winner)*ADDR_W +: ADDR_W];
                        wdata_q <= wdata[int'(winner)*DATA_W +: DATA_W];
                        if (advance) ptr <= ptr_next;
                    end
                end
                S_ISSUE: wcnt <= CNT_W'(MEM_LAT - 1);
                S_WAIT: begin
                    // Captured for writes too; the value is simply ignored then.
                    if (wcnt == '0) rdata_q <= mem_rdata;
                    else            wcnt    <= wcnt - 1'b1;
                end
                S_RESP: ;
                default: ;
            endcase
        end
    end

`ifdef MEM_PORT_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) after_resp <= 1'b0;
        else     after_resp <= (state == S_RESP);
    end
`endif

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed self-checking bench for mem_port_sched with a two-stage memory model (MEM_LAT=2).
module tb_mem_port_sched;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
`ifdef MEM_PORT_LOCK_EN
    logic [NREQ-1:0]        lock;
`endif
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        ack;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic                   mem_en;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_sched #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
`ifdef MEM_PORT_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: unwritten locations read as addr ^ 0xB5; data valid two cycles after the strobe.
    bit   [7:0] mem_data  [256];
    bit         mem_valid [256];
    logic [7:0] rd_stage;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_data[mem_addr]  <= mem_wdata;
                mem_valid[mem_addr] <= 1'b1;
            end
            rd_stage <= mem_valid[mem_addr] ? mem_data[mem_addr] : (mem_addr ^ 8'hB5);
        end
        mem_rdata <= rd_stage;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},       32'(gnt),       32'h0);
        check({tag, "_ack"},       32'(ack),       32'h0);
        check({tag, "_rdata"},     32'(rdata),     32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_mem_en"},    32'(mem_en),    32'h0);
        check({tag, "_mem_we"},    32'(mem_we),    32'h0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [2:0] order [4];
    logic [7:0] rexp  [4];
    logic [7:0] aexp  [4];

    initial begin
        // requester 2 at 0x20, requester 1 at 0x10, requester 0 at 0x01
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = {8'h20, 8'h10, 8'h01};
        wdata = {8'h3C, 8'h00, 8'h00};
`ifdef MEM_PORT_LOCK_EN
        lock  = '0;
`endif
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        rexp[0]  = 8'hB4;  rexp[1]  = 8'hA5;  rexp[2]  = 8'h95;  rexp[3]  = 8'hB4;
        aexp[0]  = 8'h01;  aexp[1]  = 8'h10;  aexp[2]  = 8'h20;  aexp[3]  = 8'h01;

        step(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(1);

        // Single read from requester 1 at 0x10 (memory holds 0xA5)
        req = 3'b010;
        step(1);
        check("rd1_gnt",      32'(gnt),      32'h2);
        check("rd1_mem_en",   32'(mem_en),   32'h1);
        check("rd1_mem_we",   32'(mem_we),   32'h0);
        check("rd1_mem_addr", 32'(mem_addr), 32'h10);
        check("rd1_busy",     32'(busy),     32'h1);
        step(1);
        check("rd1_wait_en",  32'(mem_en),   32'h0);
        check("rd1_wait_gnt", 32'(gnt),      32'h2);
        check("rd1_wait_ack", 32'(ack),      32'h0);
        step(2);
        check("rd1_ack",      32'(ack),      32'h2);
        check("rd1_rdata",    32'(rdata),    32'hA5);
        check("rd1_resp_gnt", 32'(gnt),      32'h2);
        req = 3'b000;
        step(1);
        check("rd1_idle_ack",  32'(ack),  32'h0);
        check("rd1_idle_busy", 32'(busy), 32'h0);
        check("rd1_idle_gnt",  32'(gnt),  32'h0);

        // All three requesting continuously from ptr=0: order 0,1,2,0, acks 5 cycles apart
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check($sformatf("rr%0d_gnt", k),      32'(gnt),      32'(order[k]));
            check($sformatf("rr%0d_mem_addr", k), 32'(mem_addr), 32'(aexp[k]));
            step(2);
            check($sformatf("rr%0d_pre_ack", k),  32'(ack),      32'h0);
            step(1);
            check($sformatf("rr%0d_ack", k),      32'(ack),      32'(order[k]));
            check($sformatf("rr%0d_rdata", k),    32'(rdata),    32'(rexp[k]));
            if (k == 3) req = 3'b000;
            step(1);
            check($sformatf("rr%0d_idle_busy", k), 32'(busy),    32'h0);
        end

        // Write from requester 2; its wdata changes after the grant and must be ignored
        we  = 3'b100;
        req = 3'b100;
        step(1);
        wdata[23:16] = 8'hFF;
        check("wr_gnt",       32'(gnt),       32'h4);
        check("wr_mem_en",    32'(mem_en),    32'h1);
        check("wr_mem_we",    32'(mem_we),    32'h1);
        check("wr_mem_addr",  32'(mem_addr),  32'h20);
        check("wr_mem_wdata", 32'(mem_wdata), 32'h3C);
        step(3);
        check("wr_ack",       32'(ack),       32'h4);
        req = 3'b000;
        we  = 3'b000;
        step(1);
        check("wr_mem_content", 32'(mem_data[8'h20]), 32'h3C);
        check("wr_idle_ack",    32'(ack),             32'h0);

        // Reset during WAIT aborts requester 1's read; ptr returns to 0
        req = 3'b010;
        step(1);
        check("abort_gnt", 32'(gnt), 32'h2);
        step(1);
        rst = 1'b1;
        req = 3'b000;
        step(1);
        check_reset_outputs("abort");
        rst = 1'b0;
        step(1);
        check("abort_no_ack",  32'(ack),  32'h0);
        check("abort_no_busy", 32'(busy), 32'h0);
        req = 3'b111;
        step(1);
        check("abort_ptr0_gnt", 32'(gnt), 32'h1);

        // Requester 0 drops req in WAIT; it is still acknowledged, then 1 and 2 follow
        step(1);
        req = 3'b110;
        step(2);
        check("drop_ack",   32'(ack),   32'h1);
        check("drop_rdata", 32'(rdata), 32'hB4);
        step(1);
        check("drop_idle",  32'(busy),  32'h0);
        step(1);
        check("drop_next_gnt", 32'(gnt), 32'h2);
        step(3);
        check("drop_next_ack",   32'(ack),   32'h2);
        check("drop_next_rdata", 32'(rdata), 32'hA5);
        req = 3'b100;
        step(2);
        check("drop_last_gnt", 32'(gnt), 32'h4);
        step(3);
        check("drop_last_ack",   32'(ack),   32'h4);
        check("drop_last_rdata", 32'(rdata), 32'h3C);
        req = 3'b000;
        step(1);

`ifdef MEM_PORT_LOCK_EN
        // Locked requester 0 is granted twice back to back, then requester 1
        rst = 1'b1;
        step(1);
        rst  = 1'b0;
        lock = 3'b001;
        req  = 3'b011;
        step(1);
        check("lock_gnt_a", 32'(gnt), 32'h1);
        step(3);
        check("lock_ack_a", 32'(ack), 32'h1);
        step(2);
        check("lock_gnt_b", 32'(gnt), 32'h1);
        step(3);
        check("lock_ack_b", 32'(ack), 32'h1);
        lock = 3'b000;
        req  = 3'b010;
        step(2);
        check("lock_gnt_c", 32'(gnt), 32'h2);
        step(3);
        check("lock_ack_c", 32'(ack), 32'h2);
        req = 3'b000;
        step(1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
